seq_borrow_subtractor: RTL and testbench

- Multi-cycle unsigned/two's-complement subtractor: diff = a - b - bin, over a WIDTH-bit operand.
- Processes one 4-bit nibble per clock, LSB first, through a combinational borrow-lookahead slice. A registered borrow chains between nibbles.
- Valid/ready handshake on both input and output.
- Sits in the datapath beside the 4-bit carry-lookahead adder as its subtract counterpart, for area-constrained ALU paths.

---
 rtl/alu_pkg.sv | 16 +
 rtl/bla_sub4.sv | 33 +++
 rtl/seq_borrow_subtractor.sv | 119 +++++++++++
 tb/tb_seq_borrow_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU datapath blocks.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/bla_sub4.sv
// Combinational 4-bit borrow-lookahead subtract slice: diff = a - b - bin.
module bla_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] br;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Every internal borrow is a flat sum-of-products of g/p and bin.
    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;

    assign bout = gg | (pg & bin);
    assign diff = a ^ b ^ br;

endmodule

// File: rtl/seq_borrow_subtractor.sv
// Nibble-serial subtractor: one borrow-lookahead slice reused LSB-first,
// with a registered borrow chaining between nibbles and valid/ready handshakes.
module seq_borrow_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               br;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_diff;
    logic               slice_bout;
    logic               slice_pg;
    logic               slice_gg;
    logic [WIDTH-1:0]   diff_next;
    logic               accept;
    logic               last_nib;

    assign accept   = in_valid && (state == IDLE);
    assign last_nib = (cnt == CNT_W'(NIB - 1));

    always_comb begin
        a_nib     = '0;
        b_nib     = '0;
        diff_next = diff;
        for (int k = 0; k < NIB; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
                diff_next[k*NIBBLE_W +: NIBBLE_W] = slice_diff;
            end
        end
    end

    bla_sub4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (br),
        .diff (slice_diff),
        .bout (slice_bout),
        .pg   (slice_pg),
        .gg   (slice_gg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_nib)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            br   <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
            br  <= bin;
            cnt <= '0;
        end else if (state == BUSY) begin
            diff <= diff_next;
            // Group lookahead terms chain the borrow into the next nibble.
            br   <= slice_gg | (slice_pg & br);
            cnt  <= cnt + 1'b1;
            if (last_nib) begin
                bout <= slice_bout;
                ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_next[WIDTH-1]);
                zero <= (diff_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_borrow_subtractor.sv
// Directed bench for seq_borrow_subtractor at WIDTH=16 with hand-computed results.
module tb_seq_borrow_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_borrow_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Presents one operand set, scrambles the inputs after acceptance,
    // and waits (bounded) for out_valid; lat is edges from accept to out_valid.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, output int lat);
        @(negedge clk);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = ~bi;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if ({diff, bout, ovf, zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_out: diff=%h bout=%b ovf=%b zero=%b required all 0", diff, bout, ovf, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(16'h1234, 16'h0234, 1'b0, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles required 4", lat);
        end
        n_cmp++;
        if ({diff, bout, ovf, zero} !== {16'h1000, 3'b000}) begin
            n_err++;
            $display("FAIL basic_result: diff=%h bout=%b ovf=%b zero=%b required 1000/0/0/0", diff, bout, ovf, zero);
        end
        release_out();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_exit: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_op(16'h0000, 16'h0001, 1'b0, lat);
        n_cmp++;
        if (out_valid !== 1'b1 || {diff, bout, ovf, zero} !== {16'hFFFF, 3'b100}) begin
            n_err++;
            $display("FAIL wrap: valid=%b diff=%h bout=%b ovf=%b zero=%b required 1/ffff/1/0/0", out_valid, diff, bout, ovf, zero);
        end
        release_out();
    endtask

    task automatic test_overflow();
        int lat;
        do_op(16'h8000, 16'h0001, 1'b0, lat);
        n_cmp++;
        if ({diff, bout, ovf, zero} !== {16'h7FFF, 3'b010}) begin
            n_err++;
            $display("FAIL ovf_neg: diff=%h bout=%b ovf=%b zero=%b required 7fff/0/1/0", diff, bout, ovf, zero);
        end
        release_out();
        do_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
        n_cmp++;
        if ({diff, bout, ovf, zero} !== {16'h8000, 3'b110}) begin
            n_err++;
            $display("FAIL ovf_pos: diff=%h bout=%b ovf=%b zero=%b required 8000/1/1/0", diff, bout, ovf, zero);
        end
        release_out();
    endtask

    task automatic test_bin_zero();
        int lat;
        do_op(16'h0005, 16'h0005, 1'b1, lat);
        n_cmp++;
        if ({diff, bout, ovf, zero} !== {16'hFFFF, 3'b100}) begin
            n_err++;
            $display("FAIL bin_allones: diff=%h bout=%b ovf=%b zero=%b required ffff/1/0/0", diff, bout, ovf, zero);
        end
        release_out();
        do_op(16'h0005, 16'h0005, 1'b0, lat);
        n_cmp++;
        if ({diff, bout, ovf, zero} !== {16'h0000, 3'b001}) begin
            n_err++;
            $display("FAIL zero_flag: diff=%h bout=%b ovf=%b zero=%b required 0000/0/0/1", diff, bout, ovf, zero);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        do_op(16'h00A0, 16'h0050, 1'b0, lat);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            a = 16'h1111; b = 16'h0001; bin = 1'b0;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {diff, bout, ovf, zero} !== {16'h0050, 3'b000})
                bad++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: %0d stall cycles disturbed, required 0", bad);
        end
        release_out();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0050) begin
            n_err++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b diff=%h required 1/0/0050", in_ready, out_valid, diff);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_ignored: in_ready=%b required 1 (ghost op started)", in_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            {diff, bout, ovf, zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b zero=%b required 1/0/0/0/0/0",
                     in_ready, out_valid, diff, bout, ovf, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stale_valid: out_valid=%b required 0", out_valid);
        end
        do_op(16'h00FF, 16'h0001, 1'b0, lat);
        n_cmp++;
        if (lat !== 4 || {diff, bout, ovf, zero} !== {16'h00FE, 3'b000}) begin
            n_err++;
            $display("FAIL reset_fresh_op: lat=%0d diff=%h bout=%b ovf=%b zero=%b required 4/00fe/0/0/0",
                     lat, diff, bout, ovf, zero);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_bin_zero();
        test_backpressure();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
